fetch_decode_buffer: RTL and testbench
======================================

Name: fetch_decode_buffer

Overview:
- Sits directly downstream of the instruction fetch unit and upstream of execute.
- Buffers up to DEPTH fetched {PC, instruction} pairs in a circular FIFO.
- Decodes the head entry into opcode and register fields, and back-pressures fetch when full.
- Supports a flush request from execute on a taken branch.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, ≥2.
- PC_W, 4, program counter width.
- INST_W, 4, instruction width; format is [3:2] opcode, [1:0] register index.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_pc  input  PC_W  PC of the presented instruction.
- in_instr  input  INST_W  presented instruction code.
- in_ready  output  1  buffer accepts an entry this cycle; fetch stalls its PC when low.
- flush  input  1  discard all buffered entries (taken branch).
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_pc  output  PC_W  PC of the head entry.
- out_opcode  output  2  head instr[3:2]: 00 ADD, 01 SUB, 10 LOAD, 11 BRANCH.
- out_reg  output  2  head instr[1:0].
- out_is_branch  output  1  high when out_valid and out_opcode==11.
- count  output  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset==0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1.
  - Storage contents are don't-care.
  - out_pc, out_opcode and out_reg read storage[0] but are qualified by out_valid=0.
- Push = in_valid & in_ready. Writes {in_pc, in_instr} at wr_ptr; wr_ptr advances by 1 mod DEPTH.
- Pop = out_valid & out_ready. rd_ptr advances by 1 mod DEPTH.
- in_ready = (count != DEPTH) & ~flush.
  - It is a function of the current count only; a same-cycle pop does not create room.
- out_valid = (count != 0) & ~flush.
- Head fields are combinational from storage[rd_ptr]; there is no output register.
- Latency: an entry pushed at edge N appears on out_* after edge N and is poppable in cycle N+1. There is no bypass: push into an empty buffer gives out_valid=0 in the push cycle.
- Count update at each edge:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; both pointers advance.
  - neither: unchanged.
- Flush (synchronous, sampled at the edge):
  - wr_ptr, rd_ptr and count all go to 0.
  - Any push or pop in the flush cycle is suppressed, because in_ready and out_valid are forced low.
  - Flush takes priority over every other event.
- Full (count==DEPTH): in_ready=0, and in_valid is ignored without error.
- Empty (count==0): out_valid=0, and out_ready is ignored.
- Pointer wrap is natural binary wrap with width clog2(DEPTH). Full and empty are distinguished by count, not by pointer compare.
- Reset asserted mid-operation clears all state immediately, regardless of clock. Deassertion is assumed synchronised upstream.
- No state machine beyond the occupancy counter. Control-state invariant: count ≡ (wr_ptr − rd_ptr) mod DEPTH, with count==DEPTH exactly when full and pointers are equal.

Decomposition:
- Shared package holds:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_BRANCH=2'b11;
  - instruction field bit positions (OPC_HI=3, OPC_LO=2, REG_HI=1, REG_LO=0);
  - PC_W/INST_W defaults.
- One sub-module is natural: inst_field_decode, combinational, instruction in → opcode, reg, is_branch out. Execute reuses it.
- FIFO storage and pointers live in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → count=0, out_valid=0, in_ready=1 for 3 idle cycles.
- Fill to full: push pc 0..3 with instrs 4'b0001, 4'b0110, 4'b1011, 4'b1100, out_ready=0 → count=4, in_ready=0.
  - A fifth push of pc=4 is ignored.
  - Head shows out_pc=0, out_opcode=00, out_reg=01.
- Drain with wrap:
  - From full, assert out_ready for 4 cycles → out_pc sequence 0,1,2,3; out_opcode 00,01,10,11; out_is_branch high only on the 4th.
  - Then count=0 and out_valid=0.
  - Repeat a fill → rd_ptr and wr_ptr wrap correctly and order is preserved.
- Simultaneous push/pop at count=2: in_valid=1 and out_ready=1 for 5 cycles → count stays 2, output order matches input order, no entry is lost.
- Flush priority at count=3: assert flush together with in_valid=1 and out_ready=1 →
  - in_ready=0 and out_valid=0 in that cycle;
  - next cycle count=0;
  - the following push of pc=9 becomes the head with out_pc=9.
- Async reset mid-stream at count=3: drive reset=0 between clock edges → count=0 and out_valid=0 immediately, before the next edge; on release the buffer accepts new pushes normally.

Source files
------------

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared definitions for the fetch/decode buffer and the instruction field decoder.
// The execute stage reuses the decoder, so these definitions live here.
package fetch_decode_buffer_pkg;

  localparam int unsigned DefPcW   = 4;
  localparam int unsigned DefInstW = 4;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  localparam int unsigned OPC_HI = 3;
  localparam int unsigned OPC_LO = 2;
  localparam int unsigned REG_HI = 1;
  localparam int unsigned REG_LO = 0;

endpackage

// File: rtl/fetch_decode_buffer_inst_field_decode.sv
// Combinational split of an instruction word into opcode and register index.
module inst_field_decode
  import fetch_decode_buffer_pkg::*;
#(
  parameter int unsigned INST_W = DefInstW
) (
  input  logic [INST_W-1:0] instr_i,
  output logic [1:0]        opcode_o,
  output logic [1:0]        reg_o,
  output logic              is_branch_o
);

  always_comb begin
    opcode_o    = instr_i[OPC_HI:OPC_LO];
    reg_o       = instr_i[REG_HI:REG_LO];
    is_branch_o = (opcode_o == OP_BRANCH);
  end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Circular FIFO of {pc, instr} pairs between fetch and execute; head is decoded
// combinationally. Full/empty come from the occupancy counter, not pointer compare.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = DefPcW,
  parameter int unsigned INST_W = DefInstW,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_instr_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [1:0]        out_opcode_o,
  output logic [1:0]        out_reg_o,
  output logic              out_is_branch_o,
  output logic [CntW-1:0]   count_o
);

  logic [PC_W+INST_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   push, pop;
  logic [PC_W+INST_W-1:0] head;
  logic                   dec_is_branch;

  always_comb begin
    // Ready/valid depend only on the registered count; a same-cycle pop frees nothing.
    in_ready_o  = (count_q != CntW'(DEPTH)) & ~flush_i;
    out_valid_o = (count_q != '0) & ~flush_i;
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_valid_o qualifies the head fields.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc_i, in_instr_i};
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_pc_o = head[PC_W+INST_W-1:INST_W];
  assign count_o  = count_q;

  inst_field_decode #(
    .INST_W (INST_W)
  ) u_decode (
    .instr_i     (head[INST_W-1:0]),
    .opcode_o    (out_opcode_o),
    .reg_o       (out_reg_o),
    .is_branch_o (dec_is_branch)
  );

  assign out_is_branch_o = out_valid_o & dec_is_branch;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: queue-based reference model checked on every
// falling edge, plus literal expectations at key points of each scenario.
module tb_fetch_decode_buffer;

  localparam int Depth = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       in_valid_i;
  logic [3:0] in_pc_i;
  logic [3:0] in_instr_i;
  logic       in_ready_o;
  logic       flush_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [3:0] out_pc_o;
  logic [1:0] out_opcode_o;
  logic [1:0] out_reg_o;
  logic       out_is_branch_o;
  logic [2:0] count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];

  always #5 clk_i = ~clk_i;

  fetch_decode_buffer #(
    .DEPTH  (Depth),
    .PC_W   (4),
    .INST_W (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid_i),
    .in_pc_i         (in_pc_i),
    .in_instr_i      (in_instr_i),
    .in_ready_o      (in_ready_o),
    .flush_i         (flush_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_pc_o        (out_pc_o),
    .out_opcode_o    (out_opcode_o),
    .out_reg_o       (out_reg_o),
    .out_is_branch_o (out_is_branch_o),
    .count_o         (count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {pc, instr}; flush empties it, reset empties it at once.
  function automatic bit m_in_ready();
    return (q.size() != Depth) && !flush_i;
  endfunction

  function automatic bit m_out_valid();
    return (q.size() != 0) && !flush_i;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
    end else if (flush_i) begin
      q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = in_valid_i && m_in_ready();
      do_pop  = out_ready_i && m_out_valid();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({in_pc_i, in_instr_i});
    end
  end

  always @(negedge clk_i) begin
    chk("m_count", 32'(count_o), 32'(q.size()));
    chk("m_in_ready", 32'(in_ready_o), 32'(m_in_ready()));
    chk("m_out_valid", 32'(out_valid_o), 32'(m_out_valid()));
    if (m_out_valid()) begin
      chk("m_out_pc", 32'(out_pc_o), 32'(q[0][7:4]));
      chk("m_out_opcode", 32'(out_opcode_o), 32'(q[0][3:2]));
      chk("m_out_reg", 32'(out_reg_o), 32'(q[0][1:0]));
      chk("m_is_branch", 32'(out_is_branch_o), 32'(q[0][3:2] == 2'b11));
    end else begin
      chk("m_is_branch_idle", 32'(out_is_branch_o), 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_one(input logic [3:0] pc, input logic [3:0] instr);
    in_valid_i = 1'b1;
    in_pc_i    = pc;
    in_instr_i = instr;
    cyc();
    in_valid_i = 1'b0;
  endtask

  logic [3:0] fill_instr [4];

  initial begin
    fill_instr[0] = 4'b0001;
    fill_instr[1] = 4'b0110;
    fill_instr[2] = 4'b1011;
    fill_instr[3] = 4'b1100;

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_pc_i     = '0;
    in_instr_i  = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("idle_count", 32'(count_o), 32'd0);
      chk("idle_out_valid", 32'(out_valid_o), 32'd0);
      chk("idle_in_ready", 32'(in_ready_o), 32'd1);
      cyc();
    end

    // Fill to full, then a fifth push that must be ignored
    for (int i = 0; i < 4; i++) push_one(4'(i), fill_instr[i]);
    in_valid_i = 1'b1;
    in_pc_i    = 4'd4;
    in_instr_i = 4'b0000;
    settle();
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_in_ready", 32'(in_ready_o), 32'd0);
    chk("full_head_pc", 32'(out_pc_o), 32'd0);
    chk("full_head_opc", 32'(out_opcode_o), 32'd0);
    chk("full_head_reg", 32'(out_reg_o), 32'd1);
    cyc();
    in_valid_i = 1'b0;
    settle();
    chk("full_after_extra", 32'(count_o), 32'd4);

    // Drain
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_pc", 32'(out_pc_o), 32'(i));
      chk("drain_opc", 32'(out_opcode_o), 32'(i));
      chk("drain_branch", 32'(out_is_branch_o), 32'(i == 3));
      cyc();
    end
    out_ready_i = 1'b0;
    settle();
    chk("drained_count", 32'(count_o), 32'd0);
    chk("drained_valid", 32'(out_valid_o), 32'd0);

    // Offset pointers by one, then refill and drain across the wrap point
    push_one(4'd15, 4'b0100);
    out_ready_i = 1'b1;
    cyc();
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_one(4'(4 + i), 4'(3 * i + 1));
    settle();
    chk("refill_count", 32'(count_o), 32'd4);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("wrap_pc", 32'(out_pc_o), 32'(4 + i));
      cyc();
    end
    out_ready_i = 1'b0;

    // Simultaneous push/pop at count=2
    push_one(4'd10, 4'b0010);
    push_one(4'd11, 4'b0111);
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_pc_i    = 4'(12 + i);
      in_instr_i = 4'(i * 5);
      settle();
      chk("pp_count", 32'(count_o), 32'd2);
      chk("pp_head_pc", 32'(out_pc_o), 32'(10 + i));
      cyc();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    settle();
    chk("pp_after_head", 32'(out_pc_o), 32'd15);

    // Flush priority at count=3
    push_one(4'd2, 4'b1001);
    settle();
    chk("pre_flush_count", 32'(count_o), 32'd3);
    flush_i     = 1'b1;
    in_valid_i  = 1'b1;
    in_pc_i     = 4'd7;
    in_instr_i  = 4'b0011;
    out_ready_i = 1'b1;
    settle();
    chk("flush_in_ready", 32'(in_ready_o), 32'd0);
    chk("flush_out_valid", 32'(out_valid_o), 32'd0);
    cyc();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    settle();
    chk("post_flush_count", 32'(count_o), 32'd0);
    push_one(4'd9, 4'b1111);
    settle();
    chk("post_flush_head", 32'(out_pc_o), 32'd9);
    chk("post_flush_branch", 32'(out_is_branch_o), 32'd1);

    // Async reset mid-stream at count=3
    push_one(4'd3, 4'b0101);
    push_one(4'd8, 4'b1010);
    settle();
    chk("pre_reset_count", 32'(count_o), 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_count", 32'(count_o), 32'd0);
    chk("async_valid", 32'(out_valid_o), 32'd0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    push_one(4'd5, 4'b0100);
    push_one(4'd6, 4'b1000);
    settle();
    chk("after_reset_count", 32'(count_o), 32'd2);
    chk("after_reset_head", 32'(out_pc_o), 32'd5);
    out_ready_i = 1'b1;
    cyc();
    cyc();
    out_ready_i = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
